// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: definitions shared by the data-memory / IO controller.
//   state_t      : access FSM states (IDLE, WAIT, RESP)
//   IO_SW_ADDR   : byte address of the read-only switch/pushbutton input port
//   IO_DISP_ADDR : byte address of the write-only seven-segment display port
`timescale 1ns/1ps
package dmem_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] IO_SW_ADDR   = 16'hFFF0;
  localparam logic [15:0] IO_DISP_ADDR = 16'hFFFA;

endpackage

// File: rtl/io_sync.sv
// io_sync: W-bit wide two-flop synchroniser for asynchronous switch inputs.
//   clock : sampling clock
//   reset : synchronous active-high reset, clears both flop stages
//   din   : asynchronous inputs
//   dout  : synchronised outputs, two clock cycles behind din
`timescale 1ns/1ps
module io_sync #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // Two-stage capture; the first stage may go metastable and is never used directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/dmem_io_ctrl.sv
// dmem_io_ctrl: request/ack controller for a word-organised data memory plus
// two memory-mapped IO ports (switch input at 0xFFF0, display output at 0xFFFA).
// Optional build macro: DMEM_BYTE_WRITE_EN adds the be port and byte-masked writes.
//   clock, reset : sole clock, synchronous active-high reset
//   req, we      : request (held until ack) and write select
//   addr         : big-endian byte address
//   wdata, be    : write data and byte enables (be MSB = lowest byte address)
//   rdata        : read data, valid only during ack, else 0
//   ack, err     : one-cycle completion pulse and its error qualifier
//   busy         : high from acceptance through the ack cycle
//   io_display   : seven-segment register, bits 6..0 = segments a..g
//   io_sw        : asynchronous switch/pushbutton inputs
`timescale 1ns/1ps
module dmem_io_ctrl
  import dmem_io_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 128,
  parameter int WAIT_CYC = 0,
  parameter int N_SW     = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [15:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                busy,
  output logic [6:0]          io_display,
  input  logic [N_SW-1:0]     io_sw
);

  localparam int          BYTES     = DATA_W / 8;
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] BYTES16   = 16'(BYTES);
  localparam logic [15:0] DEPTH16   = 16'(DEPTH);
  localparam logic [2:0]  WAIT_LOAD = 3'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  state_t              state;
  state_t              next_state;
  logic [2:0]          cnt;
  logic                lat_we;
  logic [15:0]         lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BYTES-1:0]    wr_be;
  logic [N_SW-1:0]     sw_sync;

  logic [15:0]         word_full;
  logic [AW-1:0]       mem_idx;
  logic                misaligned;
  logic                sel_mem;
  logic                sel_sw;
  logic                sel_disp;
  logic                bad;

  logic [DATA_W-1:0]   mem [DEPTH];

  io_sync #(.W(N_SW)) u_io_sync (
    .clock (clock),
    .reset (reset),
    .din   (io_sw),
    .dout  (sw_sync)
  );

`ifdef DMEM_BYTE_WRITE_EN
  logic [BYTES-1:0] lat_be;

  // Byte-enable latch, captured alongside the rest of the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_be <= '0;
    end else if (state == IDLE && req) begin
      lat_be <= be;
    end
  end

  assign wr_be = lat_be;
`else
  assign wr_be = '1;
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; WAIT is skipped entirely when there are no wait states.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (WAIT_CYC == 0) ? RESP : WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch and wait-state counter; inputs are ignored once accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= '0;
    end else if (state == IDLE && req) begin
      cnt       <= WAIT_LOAD;
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end else if (state == WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign word_full  = lat_addr / BYTES16;
  assign mem_idx    = word_full[AW-1:0];
  assign misaligned = (lat_addr % BYTES16) != 16'h0000;

  // Address decode of the latched request. IO ports match on exact address;
  // for aligned addresses, word index < DEPTH is the memory range test.
  always_comb begin
    sel_mem  = 1'b0;
    sel_sw   = 1'b0;
    sel_disp = 1'b0;
    bad      = 1'b0;
    if (lat_addr == IO_SW_ADDR) begin
      if (lat_we) begin
        bad = 1'b1;
      end else begin
        sel_sw = 1'b1;
      end
    end else if (lat_addr == IO_DISP_ADDR) begin
      if (lat_we) begin
        sel_disp = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end else if (misaligned) begin
      bad = 1'b1;
    end else if (word_full < DEPTH16) begin
      sel_mem = 1'b1;
    end else begin
      bad = 1'b1;
    end
  end

  assign ack  = (state == RESP);
  assign busy = (state != IDLE);
  assign err  = ack & bad;

  // Read data path: only driven during a successful read ack.
  always_comb begin
    rdata = '0;
    if (ack && !lat_we) begin
      if (sel_mem) begin
        rdata = mem[mem_idx];
      end else if (sel_sw) begin
        rdata[N_SW-1:0] = sw_sync;
      end else begin
        rdata = '0;
      end
    end else begin
      rdata = '0;
    end
  end

  // Display register; a reset in RESP wins over the pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_display <= 7'h00;
    end else if (ack && sel_disp && wr_be[0]) begin
      io_display <= lat_wdata[6:0];
    end
  end

  // Memory array, never reset; write commits on the RESP edge, enabled bytes only.
  always_ff @(posedge clock) begin
    if (!reset && ack && sel_mem && lat_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_io_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_io_ctrl;

  int checks   = 0;
  int failures = 0;

  logic        clock = 1'b0;
  logic        reset;
  // DUT a: WAIT_CYC = 2
  logic        req, we;
  logic [15:0] addr, wdata, rdata;
  logic [1:0]  be;
  logic        ack, err, busy;
  logic [6:0]  io_display;
  logic [2:0]  io_sw;
  // DUT b: WAIT_CYC = 0
  logic        req_b, we_b;
  logic [15:0] addr_b, wdata_b, rdata_b;
  logic [1:0]  be_b;
  logic        ack_b, err_b, busy_b;
  logic [6:0]  io_display_b;
  logic [2:0]  io_sw_b;

  always #5 clock = ~clock;

  dmem_io_ctrl #(.DATA_W(16), .DEPTH(128), .WAIT_CYC(2), .N_SW(3)) u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .io_display(io_display), .io_sw(io_sw)
  );

  dmem_io_ctrl #(.DATA_W(16), .DEPTH(128), .WAIT_CYC(0), .N_SW(3)) u_dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be_b),
`endif
    .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b),
    .io_display(io_display_b), .io_sw(io_sw_b)
  );

  // One access on DUT a; inputs are scrambled right after acceptance.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] b, output logic [15:0] rd,
                        output logic er, output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = 0; rd = 16'h0000; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (i == 1) begin
        addr = ~a; wdata = ~d; we = ~w; be = ~b;
      end
      if (ack) begin
        lat = i; rd = rdata; er = err;
        break;
      end
    end
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (io_display !== 7'h00) begin failures++; $display("FAIL reset_disp got=%h exp=00", io_display); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b/%b exp=0/0", busy, busy_b); end
  endtask

  task automatic test_mem_latency();
    logic [15:0] rd; logic er; int lat;
    access(1'b1, 16'h0010, 16'h1234, 2'b11, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
    access(1'b0, 16'h0010, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL rd_data got=%h exp=1234", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
    @(posedge clock); #1;
    checks++; if (ack !== 1'b0 || rdata !== 16'h0000 || err !== 1'b0)
      begin failures++; $display("FAIL after_ack got=ack%b/rd%h/err%b exp=0/0000/0", ack, rdata, err); end
  endtask

  task automatic test_io();
    logic [15:0] rd; logic er; int lat;
    io_sw = 3'b101;
    repeat (3) @(posedge clock);
    #1;
    access(1'b0, 16'hFFF0, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h0005 || er !== 1'b0) begin failures++; $display("FAIL sw_read got=%h/%b exp=0005/0", rd, er); end
    access(1'b1, 16'hFFFA, 16'h005B, 2'b01, rd, er, lat);
    checks++; if (er !== 1'b0 || lat !== 3) begin failures++; $display("FAIL disp_wr got=err%b/lat%0d exp=0/3", er, lat); end
    @(posedge clock); #1;
    checks++; if (io_display !== 7'h5B) begin failures++; $display("FAIL disp_val got=%h exp=5b", io_display); end
    access(1'b0, 16'hFFFA, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h0000 || er !== 1'b1) begin failures++; $display("FAIL disp_read got=%h/%b exp=0000/1", rd, er); end
    access(1'b1, 16'hFFF0, 16'h0011, 2'b11, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL sw_write got=err%b exp=1", er); end
    @(posedge clock); #1;
    checks++; if (io_display !== 7'h5B) begin failures++; $display("FAIL disp_hold got=%h exp=5b", io_display); end
  endtask

  task automatic test_errors();
    logic [15:0] rd; logic er; int lat;
    access(1'b0, 16'h0011, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h0000 || er !== 1'b1 || lat !== 3) begin failures++; $display("FAIL misalign_rd got=%h/%b/%0d exp=0000/1/3", rd, er, lat); end
    access(1'b1, 16'h8000, 16'hFFFF, 2'b11, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL unmapped_wr got=err%b exp=1", er); end
    access(1'b1, 16'h0011, 16'hDEAD, 2'b11, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_wr got=err%b exp=1", er); end
    access(1'b0, 16'h0010, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h1234 || er !== 1'b0) begin failures++; $display("FAIL mem_unchanged got=%h/%b exp=1234/0", rd, er); end
    access(1'b1, 16'h00FE, 16'h7E7E, 2'b11, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_wr got=err%b exp=0", er); end
    access(1'b0, 16'h00FE, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h7E7E || er !== 1'b0) begin failures++; $display("FAIL last_word_rd got=%h/%b exp=7e7e/0", rd, er); end
    access(1'b0, 16'h0100, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h0000 || er !== 1'b1) begin failures++; $display("FAIL past_end_rd got=%h/%b exp=0000/1", rd, er); end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] rd; logic er; int lat; int guard; logic saw_ack;
    access(1'b1, 16'h0020, 16'h5555, 2'b11, rd, er, lat);
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hBEEF; be = 2'b11;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL wait_entry got=busy%b/ack%b exp=1/0", busy, ack); end
    reset = 1'b1; req = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL rst_in_wait got=busy%b/ack%b exp=0/0", busy, ack); end
    checks++; if (io_display !== 7'h00) begin failures++; $display("FAIL rst_disp got=%h exp=00", io_display); end
    reset = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (ack) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL rst_no_ack got=%b exp=0", saw_ack); end
    access(1'b0, 16'h0020, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'h5555 || er !== 1'b0) begin failures++; $display("FAIL rst_no_write got=%h/%b exp=5555/0", rd, er); end
  endtask

  task automatic test_byte_write();
    logic [15:0] rd; logic er; int lat;
    access(1'b1, 16'h0004, 16'hAABB, 2'b11, rd, er, lat);
    access(1'b1, 16'h0004, 16'h1122, 2'b01, rd, er, lat);
    access(1'b0, 16'h0004, 16'h0000, 2'b11, rd, er, lat);
`ifdef DMEM_BYTE_WRITE_EN
    checks++; if (rd !== 16'hAA22) begin failures++; $display("FAIL be_merge got=%h exp=aa22", rd); end
    access(1'b1, 16'h0004, 16'h9999, 2'b00, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL be_zero_err got=%b exp=0", er); end
    access(1'b0, 16'h0004, 16'h0000, 2'b11, rd, er, lat);
    checks++; if (rd !== 16'hAA22) begin failures++; $display("FAIL be_zero_data got=%h exp=aa22", rd); end
    access(1'b1, 16'hFFFA, 16'h0033, 2'b10, rd, er, lat);
    @(posedge clock); #1;
    checks++; if (io_display !== 7'h00 || er !== 1'b0) begin failures++; $display("FAIL be_disp got=%h/%b exp=00/0", io_display, er); end
`else
    checks++; if (rd !== 16'h1122) begin failures++; $display("FAIL full_word got=%h exp=1122", rd); end
`endif
  endtask

  task automatic write_b(input logic [15:0] a, input logic [15:0] d);
    int g;
    req_b = 1'b1; we_b = 1'b1; addr_b = a; wdata_b = d; be_b = 2'b11;
    g = 0;
    do begin
      @(posedge clock); #1;
      g++;
    end while (!ack_b && g < 10);
    checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL b_write_ack got=%b exp=1", ack_b); end
    req_b = 1'b0; we_b = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int k;
    logic exp_ack;
    for (int i = 0; i < 4; i++) write_b(16'h0030 + 16'(2*i), 16'hA000 + 16'(i));
    k = 0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0030;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clock); #1;
      exp_ack = (cyc % 2) == 1;
      checks++; if (ack_b !== exp_ack) begin failures++; $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", cyc, ack_b, exp_ack); end
      checks++; if (busy_b !== exp_ack) begin failures++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy_b, exp_ack); end
      if (exp_ack && ack_b) begin
        checks++;
        if (rdata_b !== 16'hA000 + 16'(k)) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rdata_b, 16'hA000 + 16'(k)); end
        k++;
        addr_b = 16'h0030 + 16'(2*k);
        if (k == 4) req_b = 1'b0;
      end
    end
    req_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000; be = 2'b00; io_sw = 3'b000;
    req_b = 1'b0; we_b = 1'b0; addr_b = 16'h0000; wdata_b = 16'h0000; be_b = 2'b00; io_sw_b = 3'b000;
    test_reset();
    test_mem_latency();
    test_io();
    test_errors();
    test_reset_in_wait();
    test_byte_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_io_ctrl.md
DMEM_IO_CTRL -- requirements
Module: dmem_io_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits, a multiple of 8.
REQ-002 Parameter DEPTH, default 128: memory words, power of two, DEPTH*DATA_W/8 <= 0xFFF0.
REQ-003 Parameter WAIT_CYC, default 0, range 0..7: wait states between request acceptance and ack.
REQ-004 Parameter N_SW, default 3: switch/pushbutton input count, 1..DATA_W.
REQ-005 clock  input  1  sole clock; reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  1  access request, held high until ack.
REQ-008 we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  16  byte address, big-endian.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte enables, MSB = lowest byte address; present only with DMEM_BYTE_WRITE_EN.
REQ-012 rdata  output  DATA_W  read data, valid only while ack=1, else 0.
REQ-013 ack  output  1  one-cycle completion pulse.
REQ-014 err  output  1  qualifies ack: access unmapped or misaligned.
REQ-015 busy  output  1  high from acceptance until the ack cycle inclusive.
REQ-016 io_display  output  7  seven-segment register, (a..g) = bits 6..0.
REQ-017 io_sw  input  N_SW  asynchronous switch/pushbutton inputs.

Function
REQ-018 Address map: 0..DEPTH*DATA_W/8-1 memory; 0xFFF0 input port (read-only); 0xFFFA display port (write-only); all other addresses unmapped.
REQ-019 FSM states IDLE, WAIT, RESP; IDLE accepts when req=1 and latches we, addr, wdata, be.
REQ-020 WAIT_CYC=0: IDLE->RESP on acceptance; otherwise IDLE->WAIT, 3-bit counter loaded WAIT_CYC-1, WAIT->RESP when counter is 0.
REQ-021 RESP asserts ack for exactly one cycle, then returns to IDLE; latency acceptance-to-ack = WAIT_CYC+1 cycles.
REQ-022 A req still high in the cycle after ack starts a new access (back-to-back, one idle cycle minimum).
REQ-023 Changes on addr/we/wdata/be after acceptance have no effect on the pending access.
REQ-024 Memory write commits on the RESP clock edge; a read in RESP returns memcell[word index] combinationally from the latched address.
REQ-025 Word index = latched addr / (DATA_W/8); addr not a multiple of DATA_W/8 -> err=1, no write, rdata=0.
REQ-026 Input port read returns zero-extended 2-flop-synchronised io_sw; synchroniser runs every cycle.
REQ-027 Write to 0xFFFA loads io_display with wdata[6:0] on the RESP edge; err=0.
REQ-028 Unmapped access, read of 0xFFFA, or write of 0xFFF0: ack with err=1, no state change, rdata=0.
REQ-029 err=0 whenever ack=0.

Reset
REQ-030 reset forces IDLE, counter 0, ack=0, err=0, busy=0, io_display=0, synchroniser flops 0.
REQ-031 Reset during WAIT or RESP discards the pending access; no memory or display write occurs.
REQ-032 Memory contents are not reset.

Configuration
REQ-033 Macro DMEM_BYTE_WRITE_EN defined: be port present; memory writes update only enabled bytes; be=0 write acks with err=0, no change; display write requires be LSB set.
REQ-034 Macro absent: no be port; all writes are full-word.

Structure
REQ-035 Shared package dmem_io_pkg holds FSM state typedef, IO_SW_ADDR=16'hFFF0, IO_DISP_ADDR=16'hFFFA.
REQ-036 Sub-module io_sync (N_SW-wide 2-flop synchroniser) is instantiated once.

Verification
REQ-037 WAIT_CYC=2: write 0x1234 to addr 0x0010, then read 0x0010 -> ack 3 cycles after each acceptance, rdata=0x1234, err=0.
REQ-038 io_sw=3'b101, read 0xFFF0 -> rdata=0x0005 (3rd sync cycle onward); write 0x005B to 0xFFFA -> io_display=7'h5B.
REQ-039 Read 0x0011 and write 0x8000 -> ack with err=1, rdata=0, memory unchanged.
REQ-040 Assert reset in WAIT of a write 0xBEEF to 0x0020 -> no ack, busy=0 next cycle, later read of 0x0020 unchanged.
REQ-041 DMEM_BYTE_WRITE_EN: 0xAABB at 0x0004, then write 0x1122 with be=2'b01 -> read 0x0004 returns 0xAA22.
REQ-042 req held high for 4 reads, WAIT_CYC=0 -> ack every second cycle, busy toggling in step.
